// File: rtl/cv_cordic_di_encoder.sv
// Vectoring-mode CORDIC encoder: rotates (x,y) onto +x one micro-rotation per clock,
// emitting the per-step direction bits (MSB = step 0) and the K-scaled magnitude.
module cv_cordic_di_encoder #(
   parameter int DATA_W   = 16,
   parameter int ITER_MAX = 32,
   parameter int GUARD    = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [DATA_W-1:0]   x_i,
   input  logic [DATA_W-1:0]   y_i,
   input  logic [7:0]          n_i,
   output logic [ITER_MAX-1:0] theta_x_di_o,
   output logic [DATA_W:0]     mag_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                range_err_o
);

   // state  | meaning
   // S_IDLE | waiting for start; outputs hold the last result
   // S_ITER | one micro-rotation per clock until cnt == Nc
   // S_DONE | one-cycle done pulse, start ignored

   localparam int IW = DATA_W + 2 + GUARD;
   localparam int CW = $clog2(ITER_MAX + 1);
   localparam logic [CW-1:0] ITER_MAX_C = CW'(ITER_MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic signed [IW-1:0]  x_q, x_d;
   logic signed [IW-1:0]  y_q, y_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         nc_q, nc_d;
   logic [ITER_MAX-1:0]   di_q, di_d;
   logic [ITER_MAX-1:0]   theta_q, theta_d;
   logic [DATA_W:0]       mag_q, mag_d;
   logic                  range_err_q, range_err_d;
   logic                  done_q, done_d;

   logic signed [IW-1:0]  x_sh, y_sh;
   logic                  d_bit;
   logic [CW-1:0]         n_clamped;
   logic                  mag_sat;
   logic [DATA_W:0]       mag_w;

   assign x_sh  = x_q >>> cnt_q;
   assign y_sh  = y_q >>> cnt_q;
   assign d_bit = ~y_q[IW-1];

   assign n_clamped = (int'(n_i) > ITER_MAX) ? ITER_MAX_C : n_i[CW-1:0];

   // Dropping GUARD LSBs leaves one spare integer bit; if it disagrees with the
   // output sign the magnitude overflowed Q2.15 and is pinned to +max.
   assign mag_sat = x_q[IW-1] != x_q[GUARD+DATA_W];
   assign mag_w   = mag_sat ? {1'b0, {DATA_W{1'b1}}} : x_q[GUARD+DATA_W:GUARD];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         cnt_q       <= '0;
         nc_q        <= '0;
         di_q        <= '0;
         theta_q     <= '0;
         mag_q       <= '0;
         range_err_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cnt_q       <= cnt_d;
         nc_q        <= nc_d;
         di_q        <= di_d;
         theta_q     <= theta_d;
         mag_q       <= mag_d;
         range_err_q <= range_err_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      cnt_d       = cnt_q;
      nc_d        = nc_q;
      di_d        = di_q;
      theta_d     = theta_q;
      mag_d       = mag_q;
      range_err_d = range_err_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_ITER;
               x_d         = {{2{x_i[DATA_W-1]}}, x_i, {GUARD{1'b0}}};
               y_d         = {{2{y_i[DATA_W-1]}}, y_i, {GUARD{1'b0}}};
               cnt_d       = '0;
               nc_d        = n_clamped;
               di_d        = '0;
               range_err_d = x_i[DATA_W-1];
            end
         end
         S_ITER: begin
            if (cnt_q == nc_q) begin
               state_d = S_DONE;
               theta_d = di_q;
               mag_d   = mag_w;
               done_d  = 1'b1;
            end else begin
               if (d_bit) begin
                  x_d = x_q + y_sh;
                  y_d = y_q - x_sh;
               end else begin
                  x_d = x_q - y_sh;
                  y_d = y_q + x_sh;
               end
               for (int b = 0; b < ITER_MAX; b++) begin
                  if (b == ITER_MAX - 1 - int'(cnt_q)) di_d[b] = d_bit;
               end
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign theta_x_di_o = theta_q;
   assign mag_o        = mag_q;
   assign busy_o       = state_q != S_IDLE;
   assign done_o       = done_q;
   assign range_err_o  = range_err_q;

endmodule

// File: tb/tb_cv_cordic_di_encoder.sv
// Directed bench for cv_cordic_di_encoder: spec vectors with hand-derived values plus a
// reference model of the vectoring iteration for exact bit/magnitude comparison.
module tb_cv_cordic_di_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] xi, yi;
   logic [7:0]  ni;
   logic [31:0] theta;
   logic [16:0] mag;
   logic        busy, done, rerr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cv_cordic_di_encoder #(.DATA_W(16), .ITER_MAX(32), .GUARD(3)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .x_i          (xi),
      .y_i          (yi),
      .n_i          (ni),
      .theta_x_di_o (theta),
      .mag_o        (mag),
      .busy_o       (busy),
      .done_o       (done),
      .range_err_o  (rerr)
   );

   task automatic check(input string tag, input longint obs, input longint exp,
                        input longint tol);
      longint diff;
      n_tests++;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Reference vectoring CORDIC on wide integers (Q.18 internal, 3 guard bits).
   function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                 input int n, output logic [31:0] th,
                                 output logic [16:0] mg);
      longint xm, ym, xs, ys, v;
      int nc;
      xm = longint'($signed(x)) * 8;
      ym = longint'($signed(y)) * 8;
      nc = (n > 32) ? 32 : n;
      th = '0;
      for (int i = 0; i < nc; i++) begin
         xs = xm >>> i;
         ys = ym >>> i;
         if (ym >= 0) begin
            th[31-i] = 1'b1;
            xm = xm + ys;
            ym = ym - xs;
         end else begin
            xm = xm - ys;
            ym = ym + xs;
         end
      end
      v = xm >>> 3;
      if (v > 65535 || v < -65536) mg = 17'h0FFFF;
      else mg = v[16:0];
   endfunction

   task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] n, output int lat);
      @(negedge clk);
      start = 1'b1; xi = x; yi = y; ni = n;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic op_check(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] n, input logic exp_rerr);
      int lat;
      int nc;
      logic [31:0] eth;
      logic [16:0] emg;
      nc = (int'(n) > 32) ? 32 : int'(n);
      run_op(x, y, n, lat);
      model(x, y, int'(n), eth, emg);
      check({tag, "_lat"},   lat, nc + 1, 0);
      check({tag, "_theta"}, theta, eth, 0);
      check({tag, "_mag"},   mag, emg, 0);
      check({tag, "_rerr"},  rerr, exp_rerr, 0);
      @(posedge clk);
      #1 check({tag, "_donefall"}, done, 0, 0);
   endtask

   initial begin : main
      real ang, p2;
      logic [31:0] eth, prev_th;
      logic [16:0] emg, prev_mg;
      int cycles, dones, hold_err;

      rst = 1'b1; start = 1'b0; xi = '0; yi = '0; ni = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_theta", theta, 0, 0);
      check("rst_mag",   mag,   0, 0);
      check("rst_busy",  busy,  0, 0);
      check("rst_done",  done,  0, 0);
      check("rst_rerr",  rerr,  0, 0);
      rst = 1'b0;

      // 0.5 on +x: first step positive, then corrections back; |v|*K = 0x6965
      op_check("t1", 16'h4000, 16'h0000, 8'd32, 1'b0);
      check("t1_top4", theta[31:28], 4'b1000, 0);
      check("t1_magK", mag, 17'h06965, 4);

      op_check("t2", 16'h0000, 16'h7fff, 8'd32, 1'b0);
      check("t2_top4", theta[31:28], 4'b1111, 0);
      check("t2_magK", mag, 17'h0D2CA, 4);

      // 70 degrees: rebuild the angle from the direction bits and compare cos/sin
      op_check("t3", 16'h2BC7, 16'h7847, 8'd32, 1'b0);
      ang = 0.0; p2 = 1.0;
      for (int i = 0; i < 32; i++) begin
         ang = theta[31-i] ? ang + $atan(p2) : ang - $atan(p2);
         p2 = p2 / 2.0;
      end
      check("t3_cos", longint'($rtoi(32767.0 * $cos(ang) + 0.5)), 16'h2BC7, 8);
      check("t3_sin", longint'($rtoi(32767.0 * $sin(ang) + 0.5)), 16'h7847, 8);

      op_check("n0", 16'h2BC7, 16'h7847, 8'd0, 1'b0);
      check("n0_theta0", theta, 0, 0);
      check("n0_magx",   mag, 17'h02BC7, 0);

      op_check("n40", 16'h4000, 16'h2000, 8'd40, 1'b0);
      op_check("n5", 16'h4000, 16'h2000, 8'd5, 1'b0);
      check("n5_low", theta[26:0], 0, 0);

      op_check("clamp", 16'h7fff, 16'h7fff, 8'd32, 1'b0);
      check("clamp_max", mag, 17'h0FFFF, 0);

      op_check("negy", 16'h4000, 16'hC000, 8'd32, 1'b0);
      check("negy_top", theta[31], 0, 0);

      op_check("rng", 16'h8001, 16'h0100, 8'd16, 1'b1);
      op_check("rngclr", 16'h4000, 16'h2000, 8'd12, 1'b0);
      model(16'h4000, 16'h2000, 12, prev_th, prev_mg);

      // start held high throughout: outputs hold the previous result until done
      @(negedge clk);
      start = 1'b1; xi = 16'h1000; yi = 16'h3000; ni = 8'd8;
      @(posedge clk);
      cycles = 0; dones = 0; hold_err = 0;
      #1;
      while (!done && cycles < 100) begin
         if (theta !== prev_th || mag !== prev_mg || busy !== 1'b1) hold_err++;
         @(posedge clk);
         #1 cycles++;
      end
      if (done) dones++;
      start = 1'b0;
      model(16'h1000, 16'h3000, 8, eth, emg);
      check("hold_lat",   cycles, 9, 0);
      check("hold_theta", theta, eth, 0);
      check("hold_mag",   mag, emg, 0);
      repeat (6) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      check("hold_stable", hold_err, 0, 0);
      check("hold_dones",  dones, 1, 0);
      check("hold_idle",   busy, 0, 0);

      // synchronous reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; xi = 16'h8001; yi = 16'h0100; ni = 8'd20;
      @(posedge clk);
      #1 start = 1'b0;
      check("abort_rerr_live", rerr, 1, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_theta", theta, 0, 0);
      check("abort_mag",   mag, 0, 0);
      check("abort_busy",  busy, 0, 0);
      check("abort_rerr",  rerr, 0, 0);
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      check("abort_nodone", dones, 0, 0);

      op_check("post", 16'h0000, 16'h7fff, 8'd32, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
